// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, ALU codes, FSM states and control vector for the control sequencer
package ctrl_pkg;

  localparam int DATA_W    = 8;
  localparam int OPC_W     = 5;
  localparam int REG_SEL_W = 3;
  localparam int ALU_OP_W  = 4;

  localparam logic [OPC_W-1:0] OP_NOP   = 5'd0;
  localparam logic [OPC_W-1:0] OP_LOADI = 5'd1;
  localparam logic [OPC_W-1:0] OP_LOADA = 5'd2;
  localparam logic [OPC_W-1:0] OP_STORE = 5'd3;
  localparam logic [OPC_W-1:0] OP_MOV   = 5'd4;
  localparam logic [OPC_W-1:0] OP_MOVW  = 5'd5;
  localparam logic [OPC_W-1:0] OP_ADD   = 5'd6;
  localparam logic [OPC_W-1:0] OP_SUB   = 5'd7;
  localparam logic [OPC_W-1:0] OP_AND   = 5'd8;
  localparam logic [OPC_W-1:0] OP_OR    = 5'd9;
  localparam logic [OPC_W-1:0] OP_XOR   = 5'd10;
  localparam logic [OPC_W-1:0] OP_NOT   = 5'd11;
  localparam logic [OPC_W-1:0] OP_INC   = 5'd12;
  localparam logic [OPC_W-1:0] OP_DEC   = 5'd13;
  localparam logic [OPC_W-1:0] OP_JMP   = 5'd14;
  localparam logic [OPC_W-1:0] OP_JZ    = 5'd15;
  localparam logic [OPC_W-1:0] OP_JC    = 5'd16;
  localparam logic [OPC_W-1:0] OP_IN    = 5'd17;
  localparam logic [OPC_W-1:0] OP_OUT   = 5'd18;
  localparam logic [OPC_W-1:0] OP_HLT   = 5'd19;
  // 20 and 21 are reserved: legal, executed as NOP without flagging
  localparam logic [OPC_W-1:0] OP_LAST_LEGAL = 5'b10101;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NOT = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_INC = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_DEC = 4'd7;

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM2    = 3'd4,
    S_IO_WAIT = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  typedef struct packed {
    logic                 rom_re;
    logic                 ir_load;
    logic                 wreg_we;
    logic                 wreg_re;
    logic                 reg_we;
    logic [REG_SEL_W-1:0] reg_sel;
    logic                 ram_re;
    logic                 ram_we;
    logic                 ram_addr_en;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 alu_en;
    logic                 pc_load;
    logic                 pc_en;
    logic                 rom_to_databus;
    logic                 rn_to_databus;
    logic                 in_to_databus;
    logic                 out_en;
    logic                 in_ready;
    logic                 halt;
    logic                 illegal_op;
  } ctrl_t;

  function automatic logic is_alu(input logic [OPC_W-1:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_DEC);
  endfunction

  function automatic logic [ALU_OP_W-1:0] alu_code(input logic [OPC_W-1:0] opc);
    logic [ALU_OP_W-1:0] code;
    case (opc)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_XOR:  code = ALU_XOR;
      OP_NOT:  code = ALU_NOT;
      OP_INC:  code = ALU_INC;
      OP_DEC:  code = ALU_DEC;
      default: code = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - ROM, flag, I/O handshake and datapath control bundle
interface control_sequencer_if;
  import ctrl_pkg::*;

  logic [OPC_W-1:0]     rom_opcode;
  logic [DATA_W-1:0]    rom_operand;
  logic                 zero_i, carry_i;
  logic                 in_valid, out_ready, resume;

  logic                 ROM_RE, IR_LOAD;
  logic                 WREG_WE, WREG_RE, REG_WE;
  logic [REG_SEL_W-1:0] REG_SEL;
  logic                 RAM_RE, RAM_WE, RAM_ADDR_EN;
  logic [ALU_OP_W-1:0]  ALU_OP;
  logic                 ALU_EN, PC_LOAD, PC_EN;
  logic                 ROM_TO_DATABUS, RN_TO_DATABUS, IN_TO_DATABUS, OUT_EN;
  logic                 in_ready, HALT, illegal_op;
  logic                 zero_q, carry_q;

  modport master (
    input  rom_opcode, rom_operand, zero_i, carry_i, in_valid, out_ready, resume,
    output ROM_RE, IR_LOAD, WREG_WE, WREG_RE, REG_WE, REG_SEL,
           RAM_RE, RAM_WE, RAM_ADDR_EN, ALU_OP, ALU_EN, PC_LOAD, PC_EN,
           ROM_TO_DATABUS, RN_TO_DATABUS, IN_TO_DATABUS, OUT_EN,
           in_ready, HALT, illegal_op, zero_q, carry_q
  );

  modport slave (
    output rom_opcode, rom_operand, zero_i, carry_i, in_valid, out_ready, resume,
    input  ROM_RE, IR_LOAD, WREG_WE, WREG_RE, REG_WE, REG_SEL,
           RAM_RE, RAM_WE, RAM_ADDR_EN, ALU_OP, ALU_EN, PC_LOAD, PC_EN,
           ROM_TO_DATABUS, RN_TO_DATABUS, IN_TO_DATABUS, OUT_EN,
           in_ready, HALT, illegal_op, zero_q, carry_q
  );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational state/IR/flags to control vector decode
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t               state,
  input  logic [OPC_W-1:0]     opcode,
  input  logic [REG_SEL_W-1:0] reg_field,
  input  logic                 zero_q,
  input  logic                 carry_q,
  input  logic                 in_valid,
  input  logic                 out_ready,
  input  logic                 resume,
  output ctrl_t                ctrl
);

  // EXEC and IO_WAIT share this so a stalled transfer completes exactly as an unstalled one
  function automatic ctrl_t io_ctrl(input logic [OPC_W-1:0] opc, input logic iv, input logic ordy);
    ctrl_t c;
    c = '0;
    if (opc == OP_IN) begin
      if (iv) begin
        c.in_to_databus = 1'b1;
        c.wreg_we       = 1'b1;
        c.in_ready      = 1'b1;
        c.pc_en         = 1'b1;
      end
    end else if (opc == OP_OUT) begin
      c.wreg_re = 1'b1;
      if (ordy) begin
        c.out_en = 1'b1;
        c.pc_en  = 1'b1;
      end
    end
    return c;
  endfunction

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH:   ctrl.rom_re  = 1'b1;
      S_DECODE:  ctrl.ir_load = 1'b1;
      S_MEM2: begin
        ctrl.ram_addr_en = 1'b1;
        ctrl.ram_re      = 1'b1;
        ctrl.wreg_we     = 1'b1;
        ctrl.pc_en       = 1'b1;
      end
      S_HALT: begin
        ctrl.halt  = 1'b1;
        ctrl.pc_en = resume;
      end
      S_IO_WAIT: ctrl = io_ctrl(opcode, in_valid, out_ready);
      S_EXEC: begin
        ctrl.pc_en = 1'b1;
        case (opcode)
          OP_NOP: ;
          OP_LOADI: begin
            ctrl.rom_to_databus = 1'b1;
            ctrl.wreg_we        = 1'b1;
          end
          OP_STORE: begin
            ctrl.ram_addr_en = 1'b1;
            ctrl.ram_we      = 1'b1;
            ctrl.wreg_re     = 1'b1;
          end
          OP_MOV: begin
            ctrl.wreg_we       = 1'b1;
            ctrl.rn_to_databus = 1'b1;
            ctrl.reg_sel       = reg_field;
          end
          OP_MOVW: begin
            ctrl.wreg_re = 1'b1;
            ctrl.reg_we  = 1'b1;
            ctrl.reg_sel = reg_field;
          end
          OP_LOADA: begin
            ctrl.ram_addr_en = 1'b1;
            ctrl.ram_re      = 1'b1;
            ctrl.pc_en       = 1'b0;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ctrl.alu_op  = alu_code(opcode);
            ctrl.alu_en  = 1'b1;
            ctrl.wreg_we = 1'b1;
            ctrl.reg_sel = reg_field;
          end
          OP_NOT, OP_INC, OP_DEC: begin
            ctrl.alu_op  = alu_code(opcode);
            ctrl.alu_en  = 1'b1;
            ctrl.wreg_we = 1'b1;
          end
          OP_JMP, OP_JZ, OP_JC: begin
            if ((opcode == OP_JMP) || (opcode == OP_JZ && zero_q) || (opcode == OP_JC && carry_q)) begin
              ctrl.pc_load        = 1'b1;
              ctrl.rom_to_databus = 1'b1;
              ctrl.pc_en          = 1'b0;
            end
          end
          OP_HLT: begin
            ctrl.halt  = 1'b1;
            ctrl.pc_en = 1'b0;
          end
          OP_IN, OP_OUT: ctrl = io_ctrl(opcode, in_valid, out_ready);
          default: ctrl.illegal_op = (opcode > OP_LAST_LEGAL);
        endcase
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle FETCH/DECODE/EXEC sequencer holding FSM, IR and flags
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  control_sequencer_if.master bus
);

  state_t              state_q, state_d;
  logic [OPC_W-1:0]    ir_opc_q, ir_opc_d;
  logic [DATA_W-1:0]   ir_opr_q, ir_opr_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  ctrl_t               ctrl;

  always_comb begin
    state_d  = state_q;
    ir_opc_d = ir_opc_q;
    ir_opr_d = ir_opr_q;
    zero_d   = zero_q;
    carry_d  = carry_q;

    if (state_q == S_DECODE) begin
      ir_opc_d = bus.rom_opcode;
      ir_opr_d = bus.rom_operand;
    end
    if (state_q == S_EXEC && is_alu(ir_opc_q)) begin
      zero_d  = bus.zero_i;
      carry_d = bus.carry_i;
    end

    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_MEM2:   state_d = S_FETCH;
      S_HALT:   state_d = bus.resume ? S_FETCH : S_HALT;
      S_EXEC, S_IO_WAIT: begin
        case (ir_opc_q)
          OP_LOADA: state_d = S_MEM2;
          OP_HLT:   state_d = S_HALT;
          OP_IN:    state_d = bus.in_valid  ? S_FETCH : S_IO_WAIT;
          OP_OUT:   state_d = bus.out_ready ? S_FETCH : S_IO_WAIT;
          default:  state_d = S_FETCH;
        endcase
      end
      default:  state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      ir_opc_q <= '0;
      ir_opr_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_opc_q <= ir_opc_d;
      ir_opr_q <= ir_opr_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (ir_opc_q),
    .reg_field (ir_opr_q[REG_SEL_W-1:0]),
    .zero_q    (zero_q),
    .carry_q   (carry_q),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .resume    (bus.resume),
    .ctrl      (ctrl)
  );

  assign bus.ROM_RE         = ctrl.rom_re;
  assign bus.IR_LOAD        = ctrl.ir_load;
  assign bus.WREG_WE        = ctrl.wreg_we;
  assign bus.WREG_RE        = ctrl.wreg_re;
  assign bus.REG_WE         = ctrl.reg_we;
  assign bus.REG_SEL        = ctrl.reg_sel;
  assign bus.RAM_RE         = ctrl.ram_re;
  assign bus.RAM_WE         = ctrl.ram_we;
  assign bus.RAM_ADDR_EN    = ctrl.ram_addr_en;
  assign bus.ALU_OP         = ctrl.alu_op;
  assign bus.ALU_EN         = ctrl.alu_en;
  assign bus.PC_LOAD        = ctrl.pc_load;
  assign bus.PC_EN          = ctrl.pc_en;
  assign bus.ROM_TO_DATABUS = ctrl.rom_to_databus;
  assign bus.RN_TO_DATABUS  = ctrl.rn_to_databus;
  assign bus.IN_TO_DATABUS  = ctrl.in_to_databus;
  assign bus.OUT_EN         = ctrl.out_en;
  assign bus.in_ready       = ctrl.in_ready;
  assign bus.HALT           = ctrl.halt;
  assign bus.illegal_op     = ctrl.illegal_op;
  assign bus.zero_q         = zero_q;
  assign bus.carry_q        = carry_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic ctrl_t obs();
    ctrl_t o;
    o.rom_re         = bus.ROM_RE;
    o.ir_load        = bus.IR_LOAD;
    o.wreg_we        = bus.WREG_WE;
    o.wreg_re        = bus.WREG_RE;
    o.reg_we         = bus.REG_WE;
    o.reg_sel        = bus.REG_SEL;
    o.ram_re         = bus.RAM_RE;
    o.ram_we         = bus.RAM_WE;
    o.ram_addr_en    = bus.RAM_ADDR_EN;
    o.alu_op         = bus.ALU_OP;
    o.alu_en         = bus.ALU_EN;
    o.pc_load        = bus.PC_LOAD;
    o.pc_en          = bus.PC_EN;
    o.rom_to_databus = bus.ROM_TO_DATABUS;
    o.rn_to_databus  = bus.RN_TO_DATABUS;
    o.in_to_databus  = bus.IN_TO_DATABUS;
    o.out_en         = bus.OUT_EN;
    o.in_ready       = bus.in_ready;
    o.halt           = bus.HALT;
    o.illegal_op     = bus.illegal_op;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input ctrl_t e);
    ctrl_t o;
    #1;
    o = obs();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic c);
    total++;
    assert ({bus.zero_q, bus.carry_q} === {z, c}) else begin
      bad++;
      $error("FAIL %s: got z=%b c=%b want z=%b c=%b", tag, bus.zero_q, bus.carry_q, z, c);
    end
  endtask

  task automatic fetch_decode(input logic [OPC_W-1:0] opc, input logic [DATA_W-1:0] opr);
    ctrl_t e;
    bus.rom_opcode  = opc;
    bus.rom_operand = opr;
    e = '0; e.rom_re = 1'b1;
    chk("fetch", e);
    tick();
    e = '0; e.ir_load = 1'b1;
    chk("decode", e);
    tick();
  endtask

  initial begin
    ctrl_t e;
    bus.rom_opcode  = '0;
    bus.rom_operand = '0;
    bus.zero_i      = 1'b0;
    bus.carry_i     = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.resume      = 1'b0;

    #2;
    chk("reset_outputs", '0);
    chk_flags("reset_flags", 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("boot", '0);
    tick();

    // LOADI 0x2A: ROM_RE c1, IR_LOAD c2, EXEC c3, FETCH c4
    fetch_decode(OP_LOADI, 8'h2A);
    e = '0; e.rom_to_databus = 1'b1; e.wreg_we = 1'b1; e.pc_en = 1'b1;
    chk("loadi_exec", e);
    tick();

    bus.zero_i = 1'b1; bus.carry_i = 1'b0;
    fetch_decode(OP_SUB, 8'h03);
    e = '0; e.alu_op = 4'd1; e.alu_en = 1'b1; e.wreg_we = 1'b1; e.reg_sel = 3'd3; e.pc_en = 1'b1;
    chk("sub_exec", e);
    tick();
    chk_flags("sub_flags", 1'b1, 1'b0);
    bus.zero_i = 1'b0;

    fetch_decode(OP_JZ, 8'h10);
    e = '0; e.pc_load = 1'b1; e.rom_to_databus = 1'b1;
    chk("jz_taken", e);
    tick();

    fetch_decode(OP_JC, 8'h20);
    e = '0; e.pc_en = 1'b1;
    chk("jc_not_taken", e);
    tick();

    bus.zero_i = 1'b0; bus.carry_i = 1'b1;
    fetch_decode(OP_ADD, 8'hF9);
    e = '0; e.alu_op = 4'd0; e.alu_en = 1'b1; e.wreg_we = 1'b1; e.reg_sel = 3'd1; e.pc_en = 1'b1;
    chk("add_exec", e);
    tick();
    chk_flags("add_flags", 1'b0, 1'b1);

    fetch_decode(OP_JZ, 8'h10);
    e = '0; e.pc_en = 1'b1;
    chk("jz_not_taken", e);
    tick();

    fetch_decode(OP_JC, 8'h20);
    e = '0; e.pc_load = 1'b1; e.rom_to_databus = 1'b1;
    chk("jc_taken", e);
    tick();

    // non-ALU instructions must leave the flags alone even with live ALU flags
    bus.zero_i = 1'b1; bus.carry_i = 1'b0;
    fetch_decode(OP_MOV, 8'h05);
    e = '0; e.wreg_we = 1'b1; e.rn_to_databus = 1'b1; e.reg_sel = 3'd5; e.pc_en = 1'b1;
    chk("mov_exec", e);
    tick();
    fetch_decode(OP_MOVW, 8'h0A);
    e = '0; e.wreg_re = 1'b1; e.reg_we = 1'b1; e.reg_sel = 3'd2; e.pc_en = 1'b1;
    chk("movw_exec", e);
    tick();
    fetch_decode(OP_STORE, 8'h40);
    e = '0; e.ram_addr_en = 1'b1; e.ram_we = 1'b1; e.wreg_re = 1'b1; e.pc_en = 1'b1;
    chk("store_exec", e);
    tick();
    chk_flags("flags_held", 1'b0, 1'b1);

    bus.zero_i = 1'b1; bus.carry_i = 1'b1;
    fetch_decode(OP_INC, 8'h07);
    e = '0; e.alu_op = 4'd6; e.alu_en = 1'b1; e.wreg_we = 1'b1; e.pc_en = 1'b1;
    chk("inc_exec", e);
    tick();
    chk_flags("inc_flags", 1'b1, 1'b1);

    fetch_decode(OP_LOADA, 8'h33);
    e = '0; e.ram_addr_en = 1'b1; e.ram_re = 1'b1;
    chk("loada_exec", e);
    tick();
    e = '0; e.ram_addr_en = 1'b1; e.ram_re = 1'b1; e.wreg_we = 1'b1; e.pc_en = 1'b1;
    chk("loada_mem2", e);
    tick();

    // IN stalls in EXEC and 5 IO_WAIT cycles; a stray resume is ignored
    fetch_decode(OP_IN, 8'h00);
    chk("in_exec_stall", '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.resume = (i == 2);
      chk("in_wait", '0);
    end
    tick();
    bus.resume = 1'b0;
    bus.in_valid = 1'b1;
    e = '0; e.in_to_databus = 1'b1; e.wreg_we = 1'b1; e.in_ready = 1'b1; e.pc_en = 1'b1;
    chk("in_complete", e);
    tick();
    bus.in_valid = 1'b0;
    e = '0; e.rom_re = 1'b1;
    chk("in_to_fetch", e);

    fetch_decode(OP_OUT, 8'h00);
    e = '0; e.wreg_re = 1'b1;
    chk("out_exec_stall", e);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("out_wait", e);
    end
    tick();
    bus.out_ready = 1'b1;
    e = '0; e.out_en = 1'b1; e.wreg_re = 1'b1; e.pc_en = 1'b1;
    chk("out_complete", e);
    tick();
    bus.out_ready = 1'b0;

    fetch_decode(OP_HLT, 8'h00);
    e = '0; e.halt = 1'b1;
    chk("hlt_exec", e);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_hold", e);
    end
    tick();
    bus.resume = 1'b1;
    e = '0; e.halt = 1'b1; e.pc_en = 1'b1;
    chk("halt_resume", e);
    tick();
    bus.resume = 1'b0;
    e = '0; e.rom_re = 1'b1;
    chk("resume_to_fetch", e);

    fetch_decode(5'b11111, 8'h00);
    e = '0; e.illegal_op = 1'b1; e.pc_en = 1'b1;
    chk("illegal_exec", e);
    tick();
    fetch_decode(OP_NOP, 8'h00);
    e = '0; e.pc_en = 1'b1;
    chk("nop_exec", e);
    tick();

    // reset in the middle of MEM2 must abort with no trailing RAM read
    fetch_decode(OP_LOADA, 8'h55);
    tick();
    e = '0; e.ram_addr_en = 1'b1; e.ram_re = 1'b1; e.wreg_we = 1'b1; e.pc_en = 1'b1;
    chk("mem2_before_reset", e);
    rst_n = 1'b0;
    chk("reset_async", '0);
    chk_flags("reset_flags_mid", 1'b0, 1'b0);
    tick();
    chk("reset_held", '0);
    rst_n = 1'b1;
    chk("boot_after_reset", '0);
    tick();
    e = '0; e.rom_re = 1'b1;
    chk("fetch_after_reset", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
